// File: rtl/imem_responder_if.sv
// rtl/imem_responder_if.sv - instruction fetch req/gnt/rvalid bundle between core and memory responder
interface imem_responder_if;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic [6:0]  instr_rdata_intg_o;
    logic        instr_err_o;

    modport slave (
        input  instr_req_i,
        input  instr_addr_i,
        output instr_gnt_o,
        output instr_rvalid_o,
        output instr_rdata_o,
        output instr_rdata_intg_o,
        output instr_err_o
    );

    modport master (
        output instr_req_i,
        output instr_addr_i,
        input  instr_gnt_o,
        input  instr_rvalid_o,
        input  instr_rdata_o,
        input  instr_rdata_intg_o,
        input  instr_err_o
    );
endinterface

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - program RAM answering instruction fetches in order after a fixed latency
module imem_responder #(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned READ_LATENCY    = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    imem_responder_if.slave    bus,
    input  logic               stall_i,
    input  logic               load_we_i,
    input  logic [31:0]        load_addr_i,
    input  logic [31:0]        load_wdata_i
);
    localparam int unsigned AW   = $clog2(MEM_WORDS);
    localparam int unsigned CW   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] SPAN = 32'(4 * MEM_WORDS);
    // One pipeline stage is {valid, err, data}; stage 0 sits in the low bits.
    localparam int unsigned SW   = 34;
    localparam int unsigned PW   = SW * READ_LATENCY;

    logic [31:0]   mem_q [MEM_WORDS];
    logic [PW-1:0] pipe_q, pipe_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0]   fetch_off, load_off;
    logic          fetch_ok, load_ok;
    logic [AW-1:0] fetch_idx, load_idx;
    logic          gnt, retire;
    logic [31:0]   rd_word;
    logic [SW-1:0] new_stage, head;

    assign fetch_off = bus.instr_addr_i - BASE_ADDR;
    assign fetch_ok  = (fetch_off < SPAN) && (fetch_off[1:0] == 2'b00);
    assign fetch_idx = fetch_off[AW+1:2];

    assign load_off  = load_addr_i - BASE_ADDR;
    assign load_ok   = (load_off < SPAN) && (load_off[1:0] == 2'b00);
    assign load_idx  = load_off[AW+1:2];

    assign head   = pipe_q[PW-1 -: SW];
    assign retire = head[SW-1];

    // A retiring response frees its slot in the same cycle, so a full
    // responder can still accept a request while answering one.
    assign gnt = bus.instr_req_i & ~stall_i & ~rst_i &
                 ((cnt_q < CW'(MAX_OUTSTANDING)) | retire);

    assign rd_word   = fetch_ok ? mem_q[fetch_idx] : 32'h0;
    assign new_stage = gnt ? {1'b1, ~fetch_ok, rd_word} : '0;

    assign pipe_d = PW'({pipe_q, new_stage});
    assign cnt_d  = cnt_q + CW'(gnt) - CW'(retire);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_q <= '0;
            cnt_q  <= '0;
        end else begin
            pipe_q <= pipe_d;
            cnt_q  <= cnt_d;
        end
    end

    // RAM is deliberately outside reset so a loaded program survives it;
    // reads happen combinationally at grant, so a same-cycle load is seen next cycle.
    always_ff @(posedge clk_i) begin
        if (load_we_i && load_ok) begin
            mem_q[load_idx] <= load_wdata_i;
        end
    end

    assign bus.instr_gnt_o        = gnt;
    assign bus.instr_rvalid_o     = retire;
    assign bus.instr_rdata_o      = retire ? head[31:0] : 32'h0;
    assign bus.instr_err_o        = retire & head[32];
    assign bus.instr_rdata_intg_o = 7'b0;
endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - random and directed fetch traffic against a cycle-scheduled response model
module tb_imem_responder;
    logic        clk = 1'b0;
    logic        rst, req, stall, load_we;
    logic [31:0] addr, load_addr, load_wdata;

    always #5 clk = ~clk;

    imem_responder_if ifa ();
    imem_responder_if ifb ();

    assign ifa.instr_req_i  = req;
    assign ifa.instr_addr_i = addr;
    assign ifb.instr_req_i  = req;
    assign ifb.instr_addr_i = addr;

    imem_responder #(.READ_LATENCY(1), .MAX_OUTSTANDING(2)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .bus(ifa), .stall_i(stall),
        .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata)
    );

    imem_responder #(.READ_LATENCY(3), .MAX_OUTSTANDING(2)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .bus(ifb), .stall_i(stall),
        .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata)
    );

    // Model: each grant books a response slot at cycle T+latency.
    int          rl [2];
    int          mo [2];
    bit          sv [2][8];
    logic [31:0] sd [2][8];
    bit          se [2][8];
    logic [31:0] mem_m [1024];
    int          cyc, n_checks, n_pass;
    logic [5:0]  gpat_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return (a < 32'd4096) && (a % 4 == 0);
    endfunction

    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int          slot, outst, due;
            bit          ret, eg;
            logic        o_gnt, o_rv, o_err;
            logic [31:0] o_rd;
            logic [6:0]  o_intg;
            string       p;
            slot  = cyc % 8;
            outst = 0;
            for (int k = 0; k < 8; k++) outst += int'(sv[d][k]);
            ret = sv[d][slot];
            eg  = req && !stall && !rst && (outst < mo[d] || ret);
            if (d == 0) begin
                o_gnt = ifa.instr_gnt_o; o_rv = ifa.instr_rvalid_o; o_rd = ifa.instr_rdata_o;
                o_err = ifa.instr_err_o; o_intg = ifa.instr_rdata_intg_o; p = "a";
            end else begin
                o_gnt = ifb.instr_gnt_o; o_rv = ifb.instr_rvalid_o; o_rd = ifb.instr_rdata_o;
                o_err = ifb.instr_err_o; o_intg = ifb.instr_rdata_intg_o; p = "b";
                gpat_b = {gpat_b[4:0], o_gnt};
            end
            check({p, ".gnt"},    32'(o_gnt),  32'(eg));
            check({p, ".rvalid"}, 32'(o_rv),   32'(ret));
            check({p, ".rdata"},  o_rd,        ret ? sd[d][slot] : 32'h0);
            check({p, ".err"},    32'(o_err),  32'(ret && se[d][slot]));
            check({p, ".intg"},   32'(o_intg), 32'h0);
            if (rst) begin
                for (int k = 0; k < 8; k++) sv[d][k] = 1'b0;
            end else begin
                if (ret) sv[d][slot] = 1'b0;
                if (eg) begin
                    due = (cyc + rl[d]) % 8;
                    sv[d][due] = 1'b1;
                    sd[d][due] = addr_ok(addr) ? mem_m[addr[11:2]] : 32'h0;
                    se[d][due] = !addr_ok(addr);
                end
            end
        end
        if (load_we && addr_ok(load_addr)) mem_m[load_addr[11:2]] = load_wdata;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0; stall = 1'b0; load_we = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic fetch(input logic [31:0] a);
        req = 1'b1; addr = a; load_we = 1'b0;
        step();
    endtask

    initial begin
        rl[0] = 1; rl[1] = 3; mo[0] = 2; mo[1] = 2;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 8; k++) sv[d][k] = 1'b0;
        cyc = 0; n_checks = 0; n_pass = 0; gpat_b = '0;
        rst = 1'b1; req = 1'b0; stall = 1'b0; load_we = 1'b0;
        addr = '0; load_addr = '0; load_wdata = '0;
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;

        // Program fill: words 0..3 fixed, the rest random.
        for (int i = 0; i < 64; i++) begin
            load_we = 1'b1; load_addr = 32'(i * 4);
            load_wdata = (i < 4) ? 32'h1111_1111 * 32'(i + 1) : $urandom;
            step();
        end
        load_we = 1'b0;

        for (int i = 0; i < 4; i++) fetch(32'(i * 4));
        idle(5);

        req = 1'b1; addr = 32'd16;
        for (int i = 0; i < 6; i++) step();
        check("b.gnt_pattern", 32'(gpat_b), 32'b110110);
        idle(5);

        fetch(32'h0000_1000);
        fetch(32'h0000_0006);
        fetch(32'h0000_0000);
        idle(5);

        fetch(32'h0);
        stall = 1'b1; req = 1'b1; addr = 32'd4;
        for (int i = 0; i < 3; i++) step();
        stall = 1'b0;
        fetch(32'd4);
        idle(5);

        req = 1'b1; addr = 32'd8;
        load_we = 1'b1; load_addr = 32'd8; load_wdata = 32'hDEAD_BEEF;
        step();
        load_we = 1'b0;
        idle(4);
        fetch(32'd8);
        idle(5);

        fetch(32'd0);
        fetch(32'd4);
        rst = 1'b1; req = 1'b1; addr = 32'd12;
        step();
        rst = 1'b0;
        idle(4);
        fetch(32'd0);
        fetch(32'd8);
        idle(5);

        for (int i = 0; i < 600; i++) begin
            int r;
            req   = ($urandom_range(0, 9) < 7);
            stall = ($urandom_range(0, 9) < 2);
            rst   = ($urandom_range(0, 99) < 2);
            r = $urandom_range(0, 19);
            if (r < 17)      addr = 32'($urandom_range(0, 63) * 4);
            else if (r == 17) addr = 32'h0000_1000 + 32'($urandom_range(0, 4095));
            else if (r == 18) addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            else             addr = $urandom;
            load_we = ($urandom_range(0, 9) < 3);
            r = $urandom_range(0, 9);
            if (r < 8)       load_addr = 32'($urandom_range(0, 63) * 4);
            else if (r == 8) load_addr = 32'($urandom_range(0, 63) * 4 + 1);
            else             load_addr = 32'h0001_0000 + 32'($urandom_range(0, 255) * 4);
            load_wdata = $urandom;
            step();
        end
        rst = 1'b0;
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the core's instruction fetch port: the memory-side end of the req/gnt/rvalid fetch protocol. Holds a word-addressed program RAM, grants fetch requests subject to an outstanding-request limit and an external stall, and returns read data in order after a fixed latency. A side-band load port fills the RAM before or during execution; it sits at the top level between the core's fetch interface and the test/boot loader.

## Interface
- MEM_WORDS, 1024: RAM depth in 32-bit words (power of two).
- BASE_ADDR, 32'h0000_0000: byte address of word 0 (aligned to 4*MEM_WORDS).
- READ_LATENCY, 1: cycles from grant to rvalid; legal 1..4.
- MAX_OUTSTANDING, 2: maximum granted-but-unanswered requests; legal 1..READ_LATENCY+1.

- clk_i  input  1  clock; all state on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- instr_req_i  input  1  fetch request from core.
- instr_addr_i  input  32  fetch byte address.
- instr_gnt_o  output  1  request accepted this cycle.
- instr_rvalid_o  output  1  response valid.
- instr_rdata_o  output  32  response data.
- instr_rdata_intg_o  output  7  integrity bits; constant 7'b0.
- instr_err_o  output  1  response is an error; valid with rvalid.
- stall_i  input  1  suppresses grant while high.
- load_we_i  input  1  RAM write strobe.
- load_addr_i  input  32  write byte address.
- load_wdata_i  input  32  write data.

## Operation
- Grant (combinational): gnt = instr_req_i & ~stall_i & ~rst_i & (outstanding < MAX_OUTSTANDING | retire), where retire = rvalid this cycle.
- Outstanding counter: +1 on gnt, -1 on rvalid, unchanged when both happen; never exceeds MAX_OUTSTANDING and never underflows.
- On a granted request, address is decoded in the same cycle:
  - in range ([BASE_ADDR, BASE_ADDR+4*MEM_WORDS)) and addr[1:0]==0: RAM word (addr-BASE_ADDR)>>2 is read, err=0.
  - otherwise: no RAM access, data=32'h0, err=1.
- Result enters a READ_LATENCY-deep shift pipeline (valid, err, data); responses leave strictly in grant order, one per cycle at most.
- rdata_o = 32'h0 and err_o = 0 whenever rvalid_o = 0.
- Load port: when load_we_i is high and load_addr_i is in range and word-aligned, load_wdata_i is written at the end of the cycle. Out-of-range or misaligned writes are dropped silently. Loads are independent of stall_i and of the fetch handshake.
- Same-cycle read (grant) and load to the same word: the fetch returns the old contents; the new value is visible to grants from the next cycle.
- Requests not granted are not stored; the core holds req/addr until it sees gnt.

## Timing
- Reset (rst_i high at an edge): pipeline valids, outstanding counter cleared. Outputs: gnt 0 (during reset), rvalid 0, rdata 32'h0, err 0, intg 7'b0. RAM contents are not reset and survive reset.
- Reset mid-operation: all in-flight responses are discarded; no rvalid occurs for requests granted before reset.
- Grant in cycle T -> rvalid in cycle T+READ_LATENCY.
- Back-to-back: with MAX_OUTSTANDING >= READ_LATENCY, one grant per cycle is sustained indefinitely (throughput 1). With MAX_OUTSTANDING < READ_LATENCY, gnt drops for the cycles in which outstanding == MAX_OUTSTANDING and no retire occurs.
- Full with retire: outstanding == MAX_OUTSTANDING and rvalid high in the same cycle -> a new request is granted that cycle.
- stall_i has same-cycle effect on gnt only; it does not delay responses already in flight.

## Test plan
- Load words 0..3 = 32'h1111_1111..32'h4444_4444, then req addrs 0,4,8,12 on consecutive cycles (READ_LATENCY=1, MAX_OUTSTANDING=2) -> gnt every cycle, rvalid on cycles T+1..T+4 with data in order, err 0.
- READ_LATENCY=3, MAX_OUTSTANDING=2, req held for 6 cycles -> gnt pattern 1,1,0,1,1,0; rvalid exactly 3 cycles after each gnt; outstanding never exceeds 2.
- Req to addr 32'h0000_1000 (MEM_WORDS=1024) and to addr 32'h0000_0006 -> rvalid with err 1, rdata 32'h0; following req to 0 -> err 0, correct data.
- stall_i high for 3 cycles while req high -> gnt 0 for those cycles, in-flight responses still arrive on schedule; gnt resumes the cycle stall_i falls.
- Grant addr 8 and load 32'hDEAD_BEEF to addr 8 in the same cycle (old value 32'h3333_3333) -> response 32'h3333_3333; next fetch of 8 returns 32'hDEAD_BEEF.
- Assert rst_i with two responses in flight -> no rvalid after reset, outstanding 0, RAM contents unchanged on next fetch.
